// File: rtl/data_bus_pkg.sv
// Address map, STATUS bit layout and region type shared by the data bus responder.
package data_bus_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

  localparam logic [7:0] OFF_TX      = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_CYC_LO  = 8'h08;
  localparam logic [7:0] OFF_CYC_HI  = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH = 8'h10;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_ERR   = 3;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

endpackage

// File: rtl/console_fifo.sv
// Console TX byte FIFO: push side from MMIO writes, valid/ready drain side.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               data_in,
  output logic                     accept,
  output logic                     valid,
  input  logic                     ready,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign valid    = !empty;
  assign pop      = valid && ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign accept   = push && (!full || pop);
  // Gate the head so the stream reads 0 while empty (storage is never reset).
  assign data_out = empty ? 8'h00 : mem[rd_ptr];

  // Byte storage; no reset needed, contents only matter behind count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-port slave: word RAM, MMIO register block and console TX FIFO.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic        mem_wr_sig_i,
  output logic [31:0] mem_rd_data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  region_e       region;
  logic [7:0]    off;
  logic [63:0]   cycle;
  logic [31:0]   hi_snap, scratch, status;
  logic          ovf, err;
  logic          push, accept, full, empty;
  logic [CW-1:0] count;
  logic          status_wr;

  assign ram_idx   = mem_addr_i[AW+1:2];
  assign off       = {mem_addr_i[7:2], 2'b00};
  assign push      = mem_wr_sig_i && (region == REG_MMIO) && (off == OFF_TX);
  assign status_wr = mem_wr_sig_i && (region == REG_MMIO) && (off == OFF_STATUS);

  // Region decode; RAM takes priority should the MMIO page ever overlap it.
  always_comb begin
    region = REG_NONE;
    if (mem_addr_i < 32'(4 * RAM_WORDS))             region = REG_RAM;
    else if (mem_addr_i[31:8] == MMIO_BASE[31:8])    region = REG_MMIO;
  end

  // STATUS word assembly.
  always_comb begin
    status            = '0;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_OVF]    = ovf;
    status[ST_ERR]    = err;
    status[15:8]      = 8'(count);
  end

  // Combinational read mux; RAM returns pre-write data during a write cycle.
  always_comb begin
    mem_rd_data_o = '0;
    case (region)
      REG_RAM:  mem_rd_data_o = ram[ram_idx];
      REG_MMIO: begin
        case (off)
          OFF_STATUS:  mem_rd_data_o = status;
          OFF_CYC_LO:  mem_rd_data_o = cycle[31:0];
          OFF_CYC_HI:  mem_rd_data_o = hi_snap;
          OFF_SCRATCH: mem_rd_data_o = scratch;
          default:     mem_rd_data_o = '0;
        endcase
      end
      default:  mem_rd_data_o = '0;
    endcase
  end

  // Synchronous RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_sig_i && region == REG_RAM) ram[ram_idx] <= mem_wr_data_i;
  end

  // MMIO state: cycle counter, coherent high-half snapshot, scratch, sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle   <= '0;
      hi_snap <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      // Presenting CYC_LO latches the high half so a later CYC_HI read pairs with it.
      if (region == REG_MMIO && off == OFF_CYC_LO) hi_snap <= cycle[63:32];
      if (mem_wr_sig_i && region == REG_MMIO && off == OFF_SCRATCH) scratch <= mem_wr_data_i;
      // Sticky set beats a same-cycle software clear.
      if (push && !accept)                       ovf <= 1'b1;
      else if (status_wr && mem_wr_data_i[ST_OVF]) ovf <= 1'b0;
      if (mem_wr_sig_i && region == REG_NONE)    err <= 1'b1;
      else if (status_wr && mem_wr_data_i[ST_ERR]) err <= 1'b0;
    end
  end

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .data_in  (mem_wr_data_i[7:0]),
    .accept   (accept),
    .valid    (tx_valid_o),
    .ready    (tx_ready_i),
    .data_out (tx_data_o),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder with a queue/array reference model.
module tb_data_bus_responder;
  localparam int          DEPTH = 8;
  localparam logic [31:0] MB    = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        wr = 1'b0, ready = 1'b0;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;

  always #5 clk = ~clk;

  data_bus_responder #(.RAM_WORDS(1024), .MMIO_BASE(MB), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr_i    (addr),
    .mem_wr_data_i (wdata),
    .mem_wr_sig_i  (wr),
    .mem_rd_data_o (rd),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (ready)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference model state
  logic [7:0]  q[$];
  logic        m_ovf = 1'b0, m_err = 1'b0;
  logic [31:0] m_scratch = '0;
  logic [31:0] mram [int];

  // Expected outputs for the cycle just driven (pre-edge state)
  logic [31:0] e_rd, e_status;
  logic        e_valid;
  logic [7:0]  e_data;

  function automatic logic [31:0] exp_status();
    return {16'b0, 8'(q.size()), 4'b0, m_err, m_ovf, (q.size() == 0), (q.size() == DEPTH)};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a < 32'd4096) return mram.exists(int'(a >> 2)) ? mram[int'(a >> 2)] : 32'h0;
    if (a[31:8] == MB[31:8]) begin
      case (a[7:0] & 8'hFC)
        8'h04:   return exp_status();
        8'h10:   return m_scratch;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // Apply this cycle's inputs to the model as if the rising edge happened.
  task automatic commit_model();
    logic pop, is_mmio, is_none, drop;
    logic [7:0] o;
    pop     = (q.size() > 0) && ready;
    is_mmio = (addr >= 32'd4096) && (addr[31:8] == MB[31:8]);
    is_none = (addr >= 32'd4096) && !is_mmio;
    o       = addr[7:0] & 8'hFC;
    drop    = 1'b0;
    if (pop) void'(q.pop_front());
    if (wr && addr < 32'd4096) mram[int'(addr >> 2)] = wdata;
    if (wr && is_mmio && o == 8'h00) begin
      if (q.size() < DEPTH) q.push_back(wdata[7:0]);
      else drop = 1'b1;
    end
    if (wr && is_mmio && o == 8'h10) m_scratch = wdata;
    if (drop) m_ovf = 1'b1;
    else if (wr && is_mmio && o == 8'h04 && wdata[2]) m_ovf = 1'b0;
    if (wr && is_none) m_err = 1'b1;
    else if (wr && is_mmio && o == 8'h04 && wdata[3]) m_err = 1'b0;
  endtask

  // Drive one bus cycle at the falling edge, snapshot expectations, advance model.
  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    @(negedge clk);
    addr = a; wdata = d; wr = w; ready = r;
    #1;
    e_rd     = exp_rd(a);
    e_status = exp_status();
    e_valid  = (q.size() > 0);
    e_data   = e_valid ? q[0] : 8'h00;
    commit_model();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", tx_data); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    apply(MB + 32'h8, 0, 0, 0);
    n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL reset_cyc_lo: got %h want 1", rd); end
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %h want 00000002", rd); end
    apply(MB + 32'h10, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_scratch: got %h want 0", rd); end
    apply(MB + 32'hC, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_cyc_hi: got %h want 0", rd); end
  endtask

  task automatic test_ram();
    logic [31:0] a, d;
    apply(32'h40, 32'hAAAA_5555, 1, 0);
    apply(32'h40, 32'h1234_5678, 1, 0);
    n_cmp++; if (rd !== 32'hAAAA_5555) begin n_bad++; $display("FAIL ram_raw_old: got %h want aaaa5555", rd); end
    apply(32'h40, 0, 0, 0);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_read: got %h want 12345678", rd); end
    for (int i = 0; i < 24; i++) begin
      a = {20'h0, 12'($urandom_range(0, 1023) << 2)} | 32'($urandom_range(0, 3));
      if ((a >> 2) == 32'h10) a = 32'h44;
      d = $urandom;
      apply(a, d, 1, 0);
      apply(a, 0, 0, 0);
      n_cmp++; if (rd !== e_rd) begin n_bad++; $display("FAIL ram_rand a=%h: got %h want %h", a, rd, e_rd); end
    end
    apply(32'h0000_0FFC, 32'hCAFE_F00D, 1, 0);
    apply(32'h0000_0FFF, 0, 0, 0);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ram_top: got %h want cafef00d", rd); end
  endtask

  task automatic test_fifo_basic();
    for (int i = 0; i < 8; i++) apply(MB, 32'h41 + 32'(i), 1, 0);
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0000_0801) begin n_bad++; $display("FAIL fifo_full: got %h want 00000801", rd); end
    apply(MB, 32'h49, 1, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL tx_read_zero: got %h want 0", rd); end
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0000_0805) begin n_bad++; $display("FAIL fifo_ovf: got %h want 00000805", rd); end
    // Push while full with the head leaving in the same cycle
    apply(MB, 32'h50, 1, 1);
    n_cmp++; if (tx_data !== 8'h41) begin n_bad++; $display("FAIL full_pop_head: got %h want 41", tx_data); end
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0000_0805) begin n_bad++; $display("FAIL full_pushpop: got %h want 00000805", rd); end
    apply(MB + 32'h4, 32'h4, 1, 0);
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0000_0801) begin n_bad++; $display("FAIL ovf_clear: got %h want 00000801", rd); end
    for (int i = 0; i < 10; i++) begin
      apply(MB + 32'h4, 0, 0, 1);
      n_cmp++; if (tx_valid !== e_valid || tx_data !== e_data || rd !== e_status) begin
        n_bad++; $display("FAIL drain[%0d]: got v=%b d=%h s=%h want v=%b d=%h s=%h", i, tx_valid, tx_data, rd, e_valid, e_data, e_status);
      end
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_random_fifo();
    logic [31:0] a, d;
    int k;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k < 5)       a = MB;
      else if (k == 5) a = MB + 32'h4;
      else             a = MB + 32'h4;
      apply(a, (k == 5) ? (d & 32'hC) : d, (k <= 5), ($urandom_range(0, 2) == 0));
      n_cmp++; if (tx_valid !== e_valid || tx_data !== e_data || rd !== e_rd) begin
        n_bad++; $display("FAIL rand_fifo[%0d]: got v=%b d=%h r=%h want v=%b d=%h r=%h", i, tx_valid, tx_data, rd, e_valid, e_data, e_rd);
      end
    end
    while (q.size() > 0) apply(MB + 32'h4, 32'h4, 1, 1);
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL rand_idle: got %h want 00000002", rd); end
  endtask

  task automatic test_cycle();
    logic [31:0] v0;
    int n;
    @(negedge clk);
    force dut.cycle = 64'h0000_0000_FFFF_FFFF;
    addr = MB + 32'h8; wr = 1'b0; ready = 1'b0;
    #1;
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cyc_lo_forced: got %h want ffffffff", rd); end
    release dut.cycle;
    apply(MB + 32'hC, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL cyc_hi_snap: got %h want 0", rd); end
    apply(MB + 32'h8, 0, 0, 0);
    v0 = rd;
    n = $urandom_range(3, 20);
    repeat (n) apply(32'h0, 0, 0, 0);
    apply(MB + 32'h8, 0, 0, 0);
    n_cmp++; if (rd - v0 !== 32'(n + 1)) begin n_bad++; $display("FAIL cyc_delta: got %0d want %0d", rd - v0, n + 1); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    d = $urandom;
    apply(MB + 32'h10, d, 1, 0);
    apply(MB + 32'h10, 0, 0, 0);
    n_cmp++; if (rd !== d) begin n_bad++; $display("FAIL scratch: got %h want %h", rd, d); end
    apply(MB + 32'h20, 32'hFFFF_FFFF, 1, 0);
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== e_status || rd[3] !== 1'b0) begin n_bad++; $display("FAIL mmio_hole_no_err: got %h want %h", rd, e_status); end
    apply(MB + 32'h20, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mmio_hole_rd: got %h want 0", rd); end
    apply(32'h8000_0000, 32'hDEAD_BEEF, 1, 0);
    apply(32'h8000_0000, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd: got %h want 0", rd); end
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0000_000A) begin n_bad++; $display("FAIL err_set: got %h want 0000000a", rd); end
    apply(MB + 32'h4, 32'h8, 1, 0);
    apply(32'h0000_1000, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL past_ram_rd: got %h want 0", rd); end
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL err_clear_rd_noset: got %h want 00000002", rd); end
  endtask

  task automatic test_reset_midstream();
    apply(MB + 32'h10, 32'h5A5A_A5A5, 1, 0);
    apply(32'h9000_0000, 0, 1, 0);
    for (int i = 0; i < 3; i++) apply(MB, 32'h60 + 32'(i), 1, 0);
    apply(MB + 32'h4, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0000_0308) begin n_bad++; $display("FAIL pre_reset_status: got %h want 00000308", rd); end
    @(negedge clk);
    wr = 1'b0; ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL async_reset: got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
    q.delete(); m_ovf = 1'b0; m_err = 1'b0; m_scratch = '0;
    @(negedge clk); reset_n = 1'b1;
    apply(MB + 32'h4, 0, 0, 1);
    n_cmp++; if (rd !== 32'h2 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_status: got %h v=%b want 00000002 v=0", rd, tx_valid); end
    apply(MB + 32'h10, 0, 0, 0);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL post_reset_scratch: got %h want 0", rd); end
    apply(32'h40, 0, 0, 0);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_retained: got %h want 12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_basic();
    test_cycle();
    test_unmapped();
    test_random_fifo();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
